// File: rtl/fifo_wr_arb_pkg.sv
// Shared definitions for the round-robin FIFO write arbiter:
// state encoding and a width helper for deriving index/counter widths.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating priority encoder: first set bit of req at or after rr_ptr,
// scanning upward and wrapping from NUM_REQ-1 back to 0.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int REQ_BW  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_BW-1:0]  rr_ptr,
  output logic               found,
  output logic [REQ_BW-1:0]  sel
);

  int                idx;
  logic [REQ_BW-1:0] idx_r;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    idx_r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Explicit wrap so non-power-of-two requester counts scan correctly.
      idx = int'(rr_ptr) + i;
      if (idx > NUM_REQ - 1) idx = idx - NUM_REQ;
      idx_r = REQ_BW'(idx);
      if (!found && req[idx_r]) begin
        found = 1'b1;
        sel   = idx_r;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter sharing one FIFO write port among NUM_REQ
// producers, with bounded bursts per ownership and full backpressure.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int REQ_BW    = clog2(NUM_REQ),
  parameter int DATA_BW   = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_BW    = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_BW-1:0] req_data,
  input  logic                       full,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       wr_din,
  output logic [DATA_BW-1:0]         din,
  output logic [REQ_BW-1:0]          grant_id,
  output logic                       busy
);

  state_e              state_q, state_d;
  logic [REQ_BW-1:0]   owner_q, owner_d;
  logic [REQ_BW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;

  logic                found;
  logic [REQ_BW-1:0]   sel;
  logic [REQ_BW-1:0]   sel_nxt;
  logic                hold;
  logic                arb_win;
  logic [CNT_BW:0]     cnt_inc;
  logic                burst_end;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .REQ_BW  (REQ_BW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .sel    (sel)
  );

  // The owner keeps the port only while still requesting; otherwise arbitration
  // runs in the same cycle starting just past the owner.
  assign hold      = (state_q == BURST) && req[owner_q];
  assign arb_win   = !full && !hold && found;
  assign cnt_inc   = {1'b0, cnt_q} + (CNT_BW+1)'(1);
  assign burst_end = (cnt_inc == (CNT_BW+1)'(BURST_LEN));
  assign sel_nxt   = (sel == REQ_BW'(NUM_REQ - 1)) ? '0 : sel + REQ_BW'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (full) begin
      if (state_q == BURST && !req[owner_q]) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (hold) begin
      if (burst_end) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc[CNT_BW-1:0];
      end
    end else if (found) begin
      owner_d  = sel;
      rr_ptr_d = sel_nxt;
      if (BURST_LEN > 1) begin
        state_d = BURST;
        cnt_d   = CNT_BW'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    gnt      = '0;
    grant_id = owner_q;
    busy     = (state_q == BURST);
    din      = '0;
    if (!full && hold) begin
      gnt[owner_q] = 1'b1;
    end else if (arb_win) begin
      gnt[sel] = 1'b1;
      grant_id = sel;
    end
    // Outputs are forced quiet for the whole reset cycle, whatever the state.
    if (!rst) begin
      gnt      = '0;
      grant_id = '0;
      busy     = 1'b0;
    end
    wr_din = |gnt;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) din = req_data[i*DATA_BW +: DATA_BW];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: three configurations (4x4, 3 requesters, burst 1)
// checked every cycle against a queue-free scan model plus literal vectors.
module tb_fifo_wr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  = 1'b0;
  logic        full = 1'b0;
  logic [3:0]  req4 = 4'b0;
  logic [2:0]  req3 = 3'b0;
  logic [3:0]  req1 = 4'b0;
  logic [15:0] data4 = 16'h8765;
  logic [11:0] data3 = 12'hCBA;
  logic [15:0] data1 = 16'h4321;

  logic [3:0] gnt4, din4, gnt1, din1, din3;
  logic [2:0] gnt3;
  logic       wr4, wr3, wr1, busy4, busy3, busy1;
  logic [1:0] id4, id3, id1;

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_wr_arb #(.NUM_REQ(4), .REQ_BW(2), .DATA_BW(4), .BURST_LEN(4), .CNT_BW(2)) u4 (
    .clk(clk), .rst(rst), .req(req4), .req_data(data4), .full(full),
    .gnt(gnt4), .wr_din(wr4), .din(din4), .grant_id(id4), .busy(busy4));

  fifo_wr_arb #(.NUM_REQ(3), .REQ_BW(2), .DATA_BW(4), .BURST_LEN(4), .CNT_BW(2)) u3 (
    .clk(clk), .rst(rst), .req(req3), .req_data(data3), .full(full),
    .gnt(gnt3), .wr_din(wr3), .din(din3), .grant_id(id3), .busy(busy3));

  fifo_wr_arb #(.NUM_REQ(4), .REQ_BW(2), .DATA_BW(4), .BURST_LEN(1), .CNT_BW(1)) u1 (
    .clk(clk), .rst(rst), .req(req1), .req_data(data1), .full(full),
    .gnt(gnt1), .wr_din(wr1), .din(din1), .grant_id(id1), .busy(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Model: last winner (-1 = none since reset) and pushes taken in the
  // current ownership (0 = no ownership held).
  int m_last [3] = '{-1, -1, -1};
  int m_used [3] = '{0, 0, 0};

  task automatic model_eval(input int id, input int n, input int blen, input logic r,
                            input logic [3:0] rq, input logic [15:0] dt, input logic fl,
                            output logic [3:0] eg, output logic [3:0] ed,
                            output logic [1:0] eid, output logic eb, output logic ew);
    int k;
    bit got;
    eg = '0; ed = '0; eid = '0; eb = 1'b0; ew = 1'b0;
    k = 0; got = 1'b0;
    if (!r) begin
      m_last[id] = -1;
      m_used[id] = 0;
      return;
    end
    eb  = (m_used[id] > 0);
    eid = (m_last[id] < 0) ? 2'd0 : 2'(m_last[id]);
    if (fl) begin
      if (m_used[id] > 0 && !rq[m_last[id]]) m_used[id] = 0;
    end else if (m_used[id] > 0 && rq[m_last[id]]) begin
      k = m_last[id];
      got = 1'b1;
      m_used[id]++;
      if (m_used[id] == blen) m_used[id] = 0;
    end else begin
      m_used[id] = 0;
      for (int j = 0; j < n; j++) begin
        int c;
        c = (m_last[id] + 1 + j) % n;
        if (!got && rq[c]) begin
          got = 1'b1;
          k = c;
        end
      end
      if (got) begin
        m_last[id] = k;
        eid = 2'(k);
        m_used[id] = (blen > 1) ? 1 : 0;
      end
    end
    if (got) begin
      eg[k] = 1'b1;
      ew = 1'b1;
      ed = dt[k*4 +: 4];
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] eg, ed;
    logic [1:0] eid;
    logic eb, ew;
    model_eval(0, 4, 4, rst, req4, data4, full, eg, ed, eid, eb, ew);
    chk("u4.gnt", gnt4, eg); chk("u4.wr_din", wr4, ew); chk("u4.din", din4, ed);
    chk("u4.grant_id", id4, eid); chk("u4.busy", busy4, eb);
    model_eval(1, 3, 4, rst, {1'b0, req3}, {4'h0, data3}, full, eg, ed, eid, eb, ew);
    chk("u3.gnt", gnt3, eg); chk("u3.wr_din", wr3, ew); chk("u3.din", din3, ed);
    chk("u3.grant_id", id3, eid); chk("u3.busy", busy3, eb);
    model_eval(2, 4, 1, rst, req1, data1, full, eg, ed, eid, eb, ew);
    chk("u1.gnt", gnt1, eg); chk("u1.wr_din", wr1, ew); chk("u1.din", din1, ed);
    chk("u1.grant_id", id1, eid); chk("u1.busy", busy1, eb);
  end

  task automatic drive(input logic r, input logic [3:0] q4, input logic [2:0] q3,
                       input logic [3:0] q1, input logic f);
    @(posedge clk);
    #1;
    rst = r; req4 = q4; req3 = q3; req1 = q1; full = f;
    @(negedge clk);
  endtask

  logic [3:0] exp_burst [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
  logic [3:0] exp_din   [10] = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h6,
                                 4'h6, 4'h6, 4'h6, 4'h5, 4'h5};
  logic [3:0] exp_rst   [5]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};

  initial begin
    rst = 1'b0; req4 = 4'b1111; req3 = 3'b111; req1 = 4'b1111; full = 1'b0;
    repeat (3) @(negedge clk);
    chk("lit.reset.gnt4", gnt4, 4'b0000);
    chk("lit.reset.wr4", wr4, 1'b0);
    chk("lit.reset.din4", din4, 4'h0);
    chk("lit.reset.gnt1", gnt1, 4'b0000);

    // Burst limit on u4, per-cycle rotation on u1.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4'b0011, 3'b000, 4'b1111, 1'b0);
      chk("lit.burst.gnt4", gnt4, exp_burst[i]);
      chk("lit.burst.din4", din4, exp_din[i]);
      chk("lit.rot.gnt1", gnt1, 4'b0001 << (i % 4));
      chk("lit.rot.busy1", busy1, 1'b0);
      if (i == 0) chk("lit.first.id4", id4, 2'd0);
    end

    // Backpressure mid-burst (owner 0, two pushes done).
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0011, 3'b000, 4'b1111, 1'b1);
      chk("lit.full.gnt4", gnt4, 4'b0000);
      chk("lit.full.wr4", wr4, 1'b0);
      chk("lit.full.busy4", busy4, 1'b1);
    end
    drive(1'b1, 4'b0011, 3'b000, 4'b1111, 1'b0);
    chk("lit.resume1.gnt4", gnt4, 4'b0001);
    drive(1'b1, 4'b0011, 3'b000, 4'b1111, 1'b0);
    chk("lit.resume2.gnt4", gnt4, 4'b0001);
    drive(1'b1, 4'b0011, 3'b000, 4'b1111, 1'b0);
    chk("lit.rotate.gnt4", gnt4, 4'b0010);

    // Early release on u4, wrap on the 3-requester instance.
    drive(1'b1, 4'b0100, 3'b010, 4'b0000, 1'b0);
    chk("lit.own2.gnt4", gnt4, 4'b0100);
    chk("lit.own1.gnt3", gnt3, 3'b010);
    drive(1'b1, 4'b1001, 3'b101, 4'b0000, 1'b0);
    chk("lit.release.gnt4", gnt4, 4'b1000);
    chk("lit.release.id4", id4, 2'd3);
    chk("lit.wrap.gnt3", gnt3, 3'b100);
    chk("lit.wrap.id3", id3, 2'd2);
    drive(1'b1, 4'b1001, 3'b001, 4'b0000, 1'b0);
    chk("lit.hold3.gnt4", gnt4, 4'b1000);
    chk("lit.wrap0.gnt3", gnt3, 3'b001);
    drive(1'b1, 4'b0001, 3'b000, 4'b0000, 1'b0);
    chk("lit.ptr0.gnt4", gnt4, 4'b0001);

    // Reset asserted mid-burst.
    drive(1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0);
    chk("lit.midrst.gnt4", gnt4, 4'b0000);
    chk("lit.midrst.busy4", busy4, 1'b0);
    chk("lit.midrst.id4", id4, 2'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0011, 3'b000, 4'b0000, 1'b0);
      chk("lit.postrst.gnt4", gnt4, exp_rst[i]);
    end

    // Mixed vectors; the model checks every cycle.
    for (int i = 0; i < 80; i++) begin
      drive(($urandom % 25) != 0, 4'($urandom), 3'($urandom), 4'($urandom),
            ($urandom % 4) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
# fifo_wr_arb

Round-robin write arbiter that shares one `fifo` instance among `NUM_REQ` producers. Each cycle it picks at most one requester and drives the FIFO's `wr_din`/`din` for it. A granted requester may hold the FIFO for up to `BURST_LEN` consecutive pushes before ownership rotates. The block sits directly in front of the FIFO write port and honours the FIFO's `full` flag.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of producers (≥2; need not be a power of 2).
- `REQ_BW`, default 2: width of requester index; ceil(log2(NUM_REQ)).
- `DATA_BW`, default 4: FIFO data width; must match the FIFO.
- `BURST_LEN`, default 4: maximum consecutive pushes per ownership (≥1).
- `CNT_BW`, default 2: burst counter width; must hold `BURST_LEN-1`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-low reset (asserted when 0).
- `req` in `NUM_REQ`: per-producer write request, level; bit i = producer i.
- `req_data` in `NUM_REQ*DATA_BW`: flattened producer data; slice i = `[i*DATA_BW +: DATA_BW]`.
- `full` in 1: FIFO full flag.
- `gnt` out `NUM_REQ`: one-hot grant. Bit i high means producer i's data is pushed this cycle.
- `wr_din` out 1: FIFO write strobe; equals OR of `gnt`.
- `din` out `DATA_BW`: selected producer data. It is 0 when `wr_din`=0.
- `grant_id` out `REQ_BW`: index of current/last owner.
- `busy` out 1: high while in `BURST`.

## Operation
- Registered state:
  - `state` ∈ {`IDLE`, `BURST`}
  - `owner` (`REQ_BW`)
  - `rr_ptr` (`REQ_BW`)
  - `cnt` (`CNT_BW`)
- Reset (`rst`=0): `state`=`IDLE`, `owner`=0, `rr_ptr`=0, `cnt`=0. While `rst`=0, `gnt`=0, `wr_din`=0, `din`=0, `grant_id`=0, `busy`=0, regardless of `req`.
- `full`=1: `gnt`=0. State, `owner`, `cnt` and `rr_ptr` hold, with one exception: if `state`=`BURST` and `req[owner]`=0, go to `IDLE` and set `cnt`=0.
- Hold condition (`full`=0): `state`=`BURST` and `req[owner]`=1. Then grant `owner` and increment `cnt`. If the incremented value reaches `BURST_LEN`, go to `IDLE` and set `cnt`=0; `rr_ptr` is already `owner+1`.
- Arbitration condition (`full`=0 and not the hold condition): scan `req` starting at `rr_ptr`, ascending, with wrap from `NUM_REQ-1` to 0. The first set bit `k` is granted. Then:
  - `owner`←k
  - `rr_ptr`←(k+1) mod `NUM_REQ`
  - if `BURST_LEN`>1: `state`←`BURST`, `cnt`←1
  - otherwise stay `IDLE`
- Arbitration with no request set: `gnt`=0, `state`←`IDLE`, `cnt`←0, `rr_ptr` unchanged.
- Owner drops `req` in `BURST`: it is released in the same cycle. Arbitration runs in that cycle from `rr_ptr`=`owner+1`, so another producer may be granted immediately.
- `grant_id` = `owner` register, or the newly picked k in a granting arbitration cycle.
- Modulo wrap uses explicit compare to `NUM_REQ-1`, not bit truncation.

## Timing
- Grant is combinational from registered state plus `req`/`full`: zero-cycle latency from request to push.
- Producer handshake: data is consumed in the cycle `gnt[i]`=1. The producer keeps `req`/data stable until it sees `gnt[i]`.
- Exactly one push per cycle maximum. `wr_din` never asserts when `full`=1.
- Rotation is guaranteed: after `BURST_LEN` pushes the owner must win arbitration again. It loses to any other requester between `owner+1` and itself in scan order.
- Reset asserted mid-burst: the next edge clears state; outputs are 0 during the reset cycle.

## Structure
- Shared package/header holds the `IDLE`/`BURST` state encoding (1 bit) and a `clog2` helper used to derive `REQ_BW`/`CNT_BW`.
- One sub-module, `rr_pick`: a combinational rotating priority encoder. Inputs `req`, `rr_ptr`; outputs `found`, `sel`.
- Top: FSM, counter, pointer registers, data mux.

## Test plan
- Reset: hold `rst`=0 with `req`=4'b1111 → `gnt`=0, `wr_din`=0. After release, the first cycle gives `gnt`=4'b0001 and `grant_id`=0.
- Burst limit: `req`=4'b0011 steady, `full`=0, `BURST_LEN`=4 → `gnt` 0001 ×4, then 0010 ×4, then 0001 again. `din` tracks the owner slice.
- Early release: owner 2 in `BURST` with `cnt`=1 drops `req`; `req`=4'b1001 → same cycle `gnt`=4'b1000, `rr_ptr`→0.
- Backpressure: `full`=1 for 3 cycles mid-burst (`cnt`=2) → `gnt`=0, `cnt` holds. After `full`=0, two more pushes by the same owner, then rotation.
- Wrap with `NUM_REQ`=3: `req`=3'b101, `rr_ptr`=2 → grant 2, `rr_ptr`→0, then grant 0.
- `BURST_LEN`=1: `req` all-ones → grants rotate 0,1,2,3,0 every cycle; `busy` stays 0.
